// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Read-side hazard tracker for the 8x16 register file. It sits in decode and
// keeps one saturating-free pending-write counter per architectural register.
// An instruction is held off (stall) when:
//   - it reads a register that still has a write in flight, or
//   - its destination register already has the maximum number of writes in
//     flight (2^CNT_W - 1).
// Writeback retires one pending write per cycle. Flush discards all tracking.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   issue_valid  decode presents an instruction this cycle
//   src1_en/src1 first source read enable / register select
//   src2_en/src2 second source read enable / register select
//   rd_en/rd     destination write enable / register select
//   wb_valid     writeback commits a register write this cycle
//   wb_reg       writeback register select
//   flush        pipeline flush; all pending writes discarded at the edge
//   stall        issue blocked this cycle (combinational)
//   busy         bit i = register i has at least one pending write
//   err          one-cycle pulse after a writeback to a register with no
//                pending write (protocol violation)
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       src1_en,
  input  logic [2:0] src1,
  input  logic       src2_en,
  input  logic [2:0] src2,
  input  logic       rd_en,
  input  logic [2:0] rd,
  input  logic       wb_valid,
  input  logic [2:0] wb_reg,
  input  logic       flush,
  output logic       stall,
  output logic [7:0] busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Per-register pending-write counters.
  logic [7:0][CNT_W-1:0] cnt_reg;
  logic [7:0][CNT_W-1:0] cnt_next;
  logic                  err_reg;
  logic                  err_next;

  logic haz1;
  logic haz2;
  logic full;
  logic accept;
  logic wb_orphan;

  // Hazards are evaluated against the counters as they stand before the
  // edge. A writeback in the same cycle does not clear a source hazard: the
  // register file has no write-to-read bypass, so the new value only becomes
  // readable after the edge.
  assign haz1 = src1_en & (cnt_reg[src1] != CNT_ZERO);
  assign haz2 = src2_en & (cnt_reg[src2] != CNT_ZERO);

  // Destination limit keeps the counter from ever wrapping. An instruction
  // whose destination matches one of its own sources is only checked against
  // earlier writes; its own increment lands at the edge and cannot stall it.
  assign full = rd_en & (cnt_reg[rd] == CNT_MAX);

  assign stall  = issue_valid & (haz1 | haz2 | full);
  assign accept = issue_valid & ~stall & ~flush;

  // A writeback with nothing pending (for example one that arrives after a
  // flush threw its entry away) is reported but otherwise ignored.
  assign wb_orphan = wb_valid & (cnt_reg[wb_reg] == CNT_ZERO);
  assign err_next  = wb_orphan & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cnt
      logic inc;
      logic dec;

      assign inc = accept & rd_en & (rd == 3'(gi));
      assign dec = wb_valid & (wb_reg == 3'(gi)) & (cnt_reg[gi] != CNT_ZERO);

      // Simultaneous issue and retire on the same register cancel out.
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        if (flush) begin
          cnt_next[gi] = CNT_ZERO;
        end else if (inc && !dec) begin
          cnt_next[gi] = cnt_reg[gi] + CNT_ONE;
        end else if (dec && !inc) begin
          cnt_next[gi] = cnt_reg[gi] - CNT_ONE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= CNT_ZERO;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end

      assign busy[gi] = (cnt_reg[gi] != CNT_ZERO);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model that keeps an integer count of outstanding writes per
// register. Inputs change just after the rising edge; stall is checked just
// before the next edge, busy/err just after it.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic       src1_en = 1'b0;
  logic [2:0] src1 = '0;
  logic       src2_en = 1'b0;
  logic [2:0] src2 = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd = '0;
  logic       wb_valid = 1'b0;
  logic [2:0] wb_reg = '0;
  logic       flush = 1'b0;
  logic       stall;
  logic [7:0] busy;
  logic       err;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .src1_en(src1_en),
    .src1(src1),
    .src2_en(src2_en),
    .src2(src2),
    .rd_en(rd_en),
    .rd(rd),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .flush(flush),
    .stall(stall),
    .busy(busy),
    .err(err)
  );

  // Reference model: number of writes in flight per register, and the
  // expected value of err after the most recent edge.
  int cnt_m[8];
  bit err_m;

  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [7:0] busy_model();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (cnt_m[i] > 0);
    return b;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input bit s1e, input int s1, input bit s2e, input int s2,
                       input bit rde, input int r, input bit wbv, input int wbr, input bit fl);
    issue_valid = iv;
    src1_en     = s1e;
    src1        = 3'(s1);
    src2_en     = s2e;
    src2        = 3'(s2);
    rd_en       = rde;
    rd          = 3'(r);
    wb_valid    = wbv;
    wb_reg      = 3'(wbr);
    flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step(input string tag);
    bit exp_stall;
    bit acc;
    int s1, s2, r, w;
    s1 = int'(src1);
    s2 = int'(src2);
    r  = int'(rd);
    w  = int'(wb_reg);
    #1;
    exp_stall = issue_valid && ((src1_en && cnt_m[s1] != 0) ||
                                (src2_en && cnt_m[s2] != 0) ||
                                (rd_en && cnt_m[r] == MAXC));
    check({tag, ".stall"}, {7'b0, stall}, {7'b0, exp_stall});
    @(posedge clk);
    acc = issue_valid && !exp_stall && !flush;
    if (flush) begin
      err_m = 1'b0;
      for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    end else begin
      err_m = wb_valid && (cnt_m[w] == 0);
      if (wb_valid && cnt_m[w] > 0) cnt_m[w] = cnt_m[w] - 1;
      if (acc && rd_en) cnt_m[r] = cnt_m[r] + 1;
    end
    #1;
    check({tag, ".busy"}, busy, busy_model());
    check({tag, ".err"}, {7'b0, err}, {7'b0, err_m});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    err_m = 1'b0;
  endtask

  initial begin
    model_reset();

    // Power-on reset.
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("por.busy", busy, 8'h00);
    check("por.err", {7'b0, err}, 8'h00);
    rst = 1'b0;

    // Asynchronous reset mid-run with two writes pending on r3.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step("rst.iss0");
    step("rst.iss1");
    check("rst.pre_busy", busy, 8'h08);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst.busy", busy, 8'h00);
    check("rst.err", {7'b0, err}, 8'h00);
    check("rst.stall", {7'b0, stall}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst.read_r3");

    // Read-after-write stall, released one cycle after the writeback.
    idle(); step("raw.idle");
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step("raw.iss_r5");
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); step("raw.read_held");
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); step("raw.read_wb");
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); step("raw.read_go");
    check("raw.busy5", busy & 8'h20, 8'h00);

    // Destination limit on r2.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); step("lim.w1");
    step("lim.w2");
    step("lim.w3");
    step("lim.w4_held");
    drive(1, 0, 0, 0, 0, 1, 2, 1, 2, 0); step("lim.w4_wb");
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); step("lim.w4_go");
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); step("lim.full_again");

    // Same-cycle issue and retire on r4.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("same.flush");
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); step("same.iss");
    drive(1, 0, 0, 0, 0, 1, 4, 1, 4, 0); step("same.iss_wb");
    check("same.busy4", busy, 8'h10);

    // Orphan writeback to r7.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step("orph.wb7");
    idle(); step("orph.after");

    // Flush with an issue presented, then a late writeback.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("fl.clear");
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step("fl.i1");
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); step("fl.i2");
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step("fl.i5");
    check("fl.busy26", busy, 8'h26);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 1); step("fl.flush_iss");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step("fl.late_wb");
    idle(); step("fl.after");

    // Randomized traffic; registers biased to 0..3 to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) > 3 ? $urandom_range(0, 7) : $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) > 1 ? $urandom_range(0, 3) : $urandom_range(0, 7),
            $urandom_range(0, 31) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
